weight_bias_loader: RTL and testbench
=====================================

WEIGHT_BIAS_LOADER -- requirements
Module: weight_bias_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning weight/bias word width.
REQ-002 SHALL have parameter NUM_WEIGHT, default 128, meaning weights per neuron.
REQ-003 SHALL have parameter MAX_NEURON, default 32, meaning highest legal neuron number.
REQ-004 SHALL have parameter MAX_LAYER, default 3, meaning highest legal layer number.
REQ-005 SHALL have one clock and an asynchronous active-high reset; ports clk (in, 1, clock) and rst (in, 1, reset).
REQ-006 SHALL have port s_valid, in, 1, stream word valid.
REQ-007 SHALL have port s_ready, out, 1, loader accepts word.
REQ-008 SHALL have port s_data, in, 32, stream word.
REQ-009 SHALL have port s_last, in, 1, final word of packet.
REQ-010 SHALL have port weightValid, out, 1, one-cycle weight strobe.
REQ-011 SHALL have port weightValue, out, DATA_WIDTH, weight word.
REQ-012 SHALL have port biasValid, out, 1, one-cycle bias strobe.
REQ-013 SHALL have port biasValue, out, DATA_WIDTH, bias word.
REQ-014 SHALL have port config_layer_num, out, 2*DATA_WIDTH+1, target layer.
REQ-015 SHALL have port config_neuron_num, out, 2*DATA_WIDTH+1, target neuron.
REQ-016 SHALL have ports busy (out, 1, packet in progress), done (out, 1, one-cycle packet-complete pulse), err (out, 1, one-cycle protocol-error pulse).

Function
REQ-017 SHALL accept a word when s_valid and s_ready are both high; s_ready high in IDLE, WEIGHT, BIAS, DRAIN, low in DONE.
REQ-018 SHALL use packet format: header {layer[31:16], neuron[15:0]}, then NUM_WEIGHT weight words, then one bias word carrying s_last; payload in s_data[DATA_WIDTH-1:0].
REQ-019 SHALL implement states IDLE, WEIGHT, BIAS, DONE, DRAIN.
REQ-020 IDLE: on accepted legal header, latch zero-extended layer/neuron into config outputs, clear weight counter, go WEIGHT.
REQ-021 SHALL treat a header as illegal if layer is 0 or >MAX_LAYER, neuron is 0 or >MAX_NEURON, or s_last is set; illegal header -> err pulse, config outputs unchanged, go DRAIN (IDLE if s_last set).
REQ-022 WEIGHT: each accepted word drives weightValue and weightValid=1 on the next cycle; counter increments; after word NUM_WEIGHT go BIAS.
REQ-023 SHALL treat s_last on any weight word as an error: the word is still emitted, err pulses, state returns to IDLE.
REQ-024 BIAS: accepted word drives biasValue and biasValid=1 next cycle; with s_last go DONE, without s_last pulse err and go DRAIN.
REQ-025 DONE: assert done for one cycle, then go IDLE.
REQ-026 DRAIN: accept and discard words (no strobes) until a word with s_last, then go IDLE.
REQ-027 weightValid and biasValid SHALL never be high in the same cycle, and each SHALL be high exactly one cycle per accepted word.
REQ-028 config_layer_num/config_neuron_num SHALL remain stable from the header through the cycle after the last weightValid, and hold afterwards until the next legal header.
REQ-029 busy SHALL be high in WEIGHT, BIAS, DONE, DRAIN.
REQ-030 Output latency SHALL be exactly one cycle from acceptance; all outputs registered.
REQ-031 Weight counter width SHALL be clog2(NUM_WEIGHT)+1 and SHALL not wrap within a packet.

Reset
REQ-032 On rst: state IDLE; s_ready=1 after deassertion; weightValid, biasValid, done, err, busy=0; weightValue, biasValue, config_layer_num, config_neuron_num=0; counter=0.
REQ-033 Reset asserted mid-packet SHALL abort immediately with no further strobes; the following packet SHALL start from IDLE.

Structure
REQ-034 State encoding, header field positions and default parameter values SHALL live in the shared include/package alongside dataWidth.
REQ-035 SHALL be one module with no sub-modules; the FSM and counter are inline.

Verification
REQ-036 Legal packet layer=1 neuron=32, weights 0..127, bias 0x0040 -> 128 weightValid strobes with values 0..127, config=1/32 stable, one biasValid=0x0040, done one cycle after biasValid.
REQ-037 Header neuron=0 followed by 129 words, last with s_last -> err pulse, zero strobes, config unchanged, IDLE after last word.
REQ-038 s_last on weight word 50 -> 50 weightValid strobes, err pulse, no biasValid, next legal packet fully accepted.
REQ-039 Bias word without s_last, then 3 extra words, last with s_last -> biasValid once, err pulse, extras discarded, no done.
REQ-040 rst asserted after 10 weights -> outputs zero asynchronously, no further strobes; a following legal packet produces 128 weights and done.
REQ-041 s_valid toggling 50% random on a legal packet -> identical strobe values/count as REQ-036, s_ready low only in DONE.

Source files
------------

// File: rtl/weight_bias_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : weight_bias_loader_pkg
// Description : Shared defaults, header field layout, FSM state encoding and
//               header legality helper for the weight/bias stream loader.
// Revision    : 1.0 - initial release
// ============================================================================
package weight_bias_loader_pkg;

  // Default parameter values for the loader
  localparam int c_def_data_width = 16;
  localparam int c_def_num_weight = 128;
  localparam int c_def_max_neuron = 32;
  localparam int c_def_max_layer  = 3;

  // Header word layout: {layer[31:16], neuron[15:0]}
  localparam int c_hdr_field_w    = 16;
  localparam int c_hdr_layer_lsb  = 16;
  localparam int c_hdr_neuron_lsb = 0;

  // Loader FSM state encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WEIGHT = 3'd1,
    ST_BIAS   = 3'd2,
    ST_DONE   = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  // Layer and neuron numbers are 1-based; zero and anything above the
  // configured maximum are rejected.
  function automatic logic hdr_fields_legal(
    input logic [c_hdr_field_w-1:0] layer,
    input logic [c_hdr_field_w-1:0] neuron,
    input int                       max_layer,
    input int                       max_neuron
  );
    return (layer  != '0) && (int'(layer)  <= max_layer) &&
           (neuron != '0) && (int'(neuron) <= max_neuron);
  endfunction

endpackage
`default_nettype wire

// File: rtl/weight_bias_loader.sv
`default_nettype none
// ============================================================================
// Module      : weight_bias_loader
// Description : Parses a 32-bit valid/ready stream of packets
//               {header, NUM_WEIGHT weights, bias(last)} into one-cycle
//               weight/bias strobes plus the latched target layer/neuron.
//               Malformed packets raise a one-cycle err pulse and the rest
//               of the packet is drained without strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_bias_loader
  import weight_bias_loader_pkg::*;
#(
  parameter int DATA_WIDTH = c_def_data_width,
  parameter int NUM_WEIGHT = c_def_num_weight,
  parameter int MAX_NEURON = c_def_max_neuron,
  parameter int MAX_LAYER  = c_def_max_layer
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [31:0]           s_data,
  input  logic                  s_last,
  output logic                  weightValid,
  output logic [DATA_WIDTH-1:0] weightValue,
  output logic                  biasValid,
  output logic [DATA_WIDTH-1:0] biasValue,
  output logic [2*DATA_WIDTH:0] config_layer_num,
  output logic [2*DATA_WIDTH:0] config_neuron_num,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int c_cnt_w = $clog2(NUM_WEIGHT) + 1;
  localparam int c_cfg_w = 2 * DATA_WIDTH + 1;
  localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(NUM_WEIGHT - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_cnt_w-1:0]      r_cnt,        w_cnt_nxt;
  logic                    r_s_ready,    w_s_ready_nxt;
  logic                    r_wvalid,     w_wvalid_nxt;
  logic [DATA_WIDTH-1:0]   r_wvalue,     w_wvalue_nxt;
  logic                    r_bvalid,     w_bvalid_nxt;
  logic [DATA_WIDTH-1:0]   r_bvalue,     w_bvalue_nxt;
  logic [c_cfg_w-1:0]      r_cfg_layer,  w_cfg_layer_nxt;
  logic [c_cfg_w-1:0]      r_cfg_neuron, w_cfg_neuron_nxt;
  logic                    r_busy,       w_busy_nxt;
  logic                    r_done,       w_done_nxt;
  logic                    r_err,        w_err_nxt;

  logic                     w_accept;
  logic [c_hdr_field_w-1:0] w_hdr_layer;
  logic [c_hdr_field_w-1:0] w_hdr_neuron;
  logic                     w_hdr_ok;
  logic [DATA_WIDTH-1:0]    w_payload;

  assign w_accept     = s_valid & r_s_ready;
  assign w_hdr_layer  = s_data[c_hdr_layer_lsb  +: c_hdr_field_w];
  assign w_hdr_neuron = s_data[c_hdr_neuron_lsb +: c_hdr_field_w];
  assign w_hdr_ok     = hdr_fields_legal(w_hdr_layer, w_hdr_neuron, MAX_LAYER, MAX_NEURON)
                        && !s_last;
  assign w_payload    = s_data[DATA_WIDTH-1:0];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode; every output is registered below
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_wvalid_nxt     = 1'b0;
    w_wvalue_nxt     = r_wvalue;
    w_bvalid_nxt     = 1'b0;
    w_bvalue_nxt     = r_bvalue;
    w_cfg_layer_nxt  = r_cfg_layer;
    w_cfg_neuron_nxt = r_cfg_neuron;
    w_done_nxt       = 1'b0;
    w_err_nxt        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_hdr_ok) begin
            w_cfg_layer_nxt  = c_cfg_w'(w_hdr_layer);
            w_cfg_neuron_nxt = c_cfg_w'(w_hdr_neuron);
            w_cnt_nxt        = '0;
            w_state_nxt      = ST_WEIGHT;
          end else begin
            // A bad header that is also the last word ends the packet here
            w_err_nxt   = 1'b1;
            w_state_nxt = s_last ? ST_IDLE : ST_DRAIN;
          end
        end
      end

      ST_WEIGHT: begin
        if (w_accept) begin
          w_wvalid_nxt = 1'b1;
          w_wvalue_nxt = w_payload;
          w_cnt_nxt    = r_cnt + 1'b1;
          if (s_last) begin
            // Truncated packet: the weight is still emitted, then abort
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (r_cnt == c_last_idx) begin
            w_state_nxt = ST_BIAS;
          end
        end
      end

      ST_BIAS: begin
        if (w_accept) begin
          w_bvalid_nxt = 1'b1;
          w_bvalue_nxt = w_payload;
          if (s_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_DRAIN;
          end
        end
      end

      ST_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      ST_DRAIN: begin
        if (w_accept && s_last) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Handshake and busy follow the state being entered so they are
    // registered alongside it.
    w_s_ready_nxt = (w_state_nxt != ST_DONE);
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
  end

  // Registered datapath, counter and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_s_ready    <= 1'b1;
      r_wvalid     <= 1'b0;
      r_wvalue     <= '0;
      r_bvalid     <= 1'b0;
      r_bvalue     <= '0;
      r_cfg_layer  <= '0;
      r_cfg_neuron <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_s_ready    <= w_s_ready_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_wvalue     <= w_wvalue_nxt;
      r_bvalid     <= w_bvalid_nxt;
      r_bvalue     <= w_bvalue_nxt;
      r_cfg_layer  <= w_cfg_layer_nxt;
      r_cfg_neuron <= w_cfg_neuron_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign s_ready           = r_s_ready;
  assign weightValid       = r_wvalid;
  assign weightValue       = r_wvalue;
  assign biasValid         = r_bvalid;
  assign biasValue         = r_bvalue;
  assign config_layer_num  = r_cfg_layer;
  assign config_neuron_num = r_cfg_neuron;
  assign busy              = r_busy;
  assign done              = r_done;
  assign err               = r_err;

endmodule
`default_nettype wire

// File: tb/tb_weight_bias_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_bias_loader
// Description : Directed self-checking bench for weight_bias_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_bias_loader;

  localparam int DW = 16;
  localparam int NW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = '0;
  logic          s_last = 1'b0;
  logic          weightValid;
  logic [DW-1:0] weightValue;
  logic          biasValid;
  logic [DW-1:0] biasValue;
  logic [2*DW:0] config_layer_num;
  logic [2*DW:0] config_neuron_num;
  logic          busy;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;

  weight_bias_loader #(
    .DATA_WIDTH(DW),
    .NUM_WEIGHT(NW),
    .MAX_NEURON(32),
    .MAX_LAYER (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_data           (s_data),
    .s_last           (s_last),
    .weightValid      (weightValid),
    .weightValue      (weightValue),
    .biasValid        (biasValid),
    .biasValue        (biasValue),
    .config_layer_num (config_layer_num),
    .config_neuron_num(config_neuron_num),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  // Monitor: event counters sampled on the falling edge
  int            cyc = 0;
  int            wcnt = 0, bcnt = 0, dcnt = 0, ecnt = 0;
  int            overlap = 0, cfgbad = 0, rdylow = 0;
  int            bias_cyc = 0, done_cyc = 0;
  logic [DW-1:0] bval = '0;
  logic [DW-1:0] wval[$];
  logic [2*DW:0] exp_layer = '0, exp_neuron = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (weightValid) begin
        wcnt++;
        wval.push_back(weightValue);
        if (config_layer_num !== exp_layer || config_neuron_num !== exp_neuron) cfgbad++;
      end
      if (biasValid) begin
        bcnt++;
        bval = biasValue;
        bias_cyc = cyc;
      end
      if (done) begin
        dcnt++;
        done_cyc = cyc;
      end
      if (err) ecnt++;
      if (weightValid && biasValid) overlap++;
      if (!s_ready) rdylow++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one stream word and hold it until accepted (bounded wait)
  task automatic send_word(input logic [31:0] d, input logic l, input bit rnd);
    int t;
    if (rnd) begin
      while ($urandom_range(0, 1) == 1) begin
        s_valid = 1'b0;
        tick(1);
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    t = 0;
    while (!s_ready && t < 50) begin
      tick(1);
      t++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL handshake: s_ready=%0b after %0d cycles, required 1", s_ready, t);
    end
    tick(1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Header, weights 0..NW-1, bias carrying s_last
  task automatic drive_packet(input int layer, input int neuron, input logic [15:0] bias,
                              input bit rnd);
    send_word({layer[15:0], neuron[15:0]}, 1'b0, rnd);
    for (int i = 0; i < NW; i++) send_word(32'(i), 1'b0, rnd);
    send_word({16'h0, bias}, 1'b1, rnd);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b need 1", s_ready); end
    total++;
    if ({weightValid, biasValid, done, err, busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b need 00000", {weightValid, biasValid, done, err, busy});
    end
    total++;
    if (weightValue !== '0 || biasValue !== '0) begin
      bad++;
      $display("FAIL reset_values: got w=%h b=%h need 0/0", weightValue, biasValue);
    end
    total++;
    if (config_layer_num !== '0 || config_neuron_num !== '0) begin
      bad++;
      $display("FAIL reset_config: got %0d/%0d need 0/0", config_layer_num, config_neuron_num);
    end
  endtask

  task automatic test_legal_packet(input bit rnd);
    int w0, b0, d0, e0, q0, r0, firstbad;
    w0 = wcnt; b0 = bcnt; d0 = dcnt; e0 = ecnt; q0 = wval.size(); r0 = rdylow;
    exp_layer = 33'd1; exp_neuron = 33'd32;
    drive_packet(1, 32, 16'h0040, rnd);
    tick(3);
    total++;
    if (wcnt - w0 != NW) begin bad++; $display("FAIL legal_wcount: got %0d need %0d", wcnt - w0, NW); end
    firstbad = -1;
    for (int i = 0; i < NW && q0 + i < wval.size(); i++)
      if (firstbad < 0 && wval[q0 + i] !== 16'(i)) firstbad = i;
    total++;
    if (firstbad >= 0) begin
      bad++;
      $display("FAIL legal_wvalues: index %0d got %h need %h", firstbad, wval[q0 + firstbad], 16'(firstbad));
    end
    total++;
    if (cfgbad != 0 || config_layer_num !== 33'd1 || config_neuron_num !== 33'd32) begin
      bad++;
      $display("FAIL legal_config: got %0d/%0d unstable=%0d need 1/32 unstable=0",
               config_layer_num, config_neuron_num, cfgbad);
    end
    total++;
    if (bcnt - b0 != 1 || bval !== 16'h0040) begin
      bad++;
      $display("FAIL legal_bias: got count=%0d val=%h need 1/0040", bcnt - b0, bval);
    end
    total++;
    if (dcnt - d0 != 1 || done_cyc != bias_cyc + 1) begin
      bad++;
      $display("FAIL legal_done: got count=%0d at +%0d need 1 at +1", dcnt - d0, done_cyc - bias_cyc);
    end
    total++;
    if (ecnt != e0 || overlap != 0) begin
      bad++;
      $display("FAIL legal_err_overlap: got err=%0d overlap=%0d need 0/0", ecnt - e0, overlap);
    end
    if (rnd) begin
      total++;
      if (rdylow - r0 != 1) begin
        bad++;
        $display("FAIL random_ready_low: got %0d cycles need 1", rdylow - r0);
      end
    end
  endtask

  task automatic test_bad_header();
    int w0, b0, d0, e0;
    w0 = wcnt; b0 = bcnt; d0 = dcnt; e0 = ecnt;
    // neuron = 0, followed by 129 words ending with s_last
    send_word({16'd1, 16'd0}, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL drain_busy: got %0b need 1", busy); end
    for (int i = 0; i < 129; i++) send_word(32'(i + 7), (i == 128), 1'b0);
    tick(2);
    total++;
    if (ecnt - e0 != 1 || wcnt != w0 || bcnt != b0 || dcnt != d0) begin
      bad++;
      $display("FAIL bad_neuron: got err=%0d w=%0d b=%0d d=%0d need 1/0/0/0",
               ecnt - e0, wcnt - w0, bcnt - b0, dcnt - d0);
    end
    total++;
    if (config_layer_num !== 33'd1 || config_neuron_num !== 33'd32 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bad_neuron_hold: got cfg=%0d/%0d busy=%0b need 1/32 busy=0",
               config_layer_num, config_neuron_num, busy);
    end
    // Otherwise legal header carrying s_last returns straight to idle
    e0 = ecnt;
    send_word({16'd1, 16'd1}, 1'b1, 1'b0);
    tick(1);
    total++;
    if (ecnt - e0 != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hdr_last: got err=%0d busy=%0b need 1/0", ecnt - e0, busy);
    end
    // layer above MAX_LAYER, one trailing word with s_last
    e0 = ecnt; w0 = wcnt;
    send_word({16'd4, 16'd1}, 1'b0, 1'b0);
    send_word(32'h5, 1'b1, 1'b0);
    tick(2);
    total++;
    if (ecnt - e0 != 1 || wcnt != w0 || busy !== 1'b0 || config_layer_num !== 33'd1) begin
      bad++;
      $display("FAIL bad_layer: got err=%0d w=%0d busy=%0b layer=%0d need 1/0/0/1",
               ecnt - e0, wcnt - w0, busy, config_layer_num);
    end
  endtask

  task automatic test_early_last();
    int w0, b0, d0, e0;
    w0 = wcnt; b0 = bcnt; d0 = dcnt; e0 = ecnt;
    exp_layer = 33'd2; exp_neuron = 33'd5;
    send_word({16'd2, 16'd5}, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) send_word(32'(i), (i == 49), 1'b0);
    tick(2);
    total++;
    if (wcnt - w0 != 50 || ecnt - e0 != 1 || bcnt != b0 || dcnt != d0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL early_last: got w=%0d err=%0d b=%0d d=%0d busy=%0b need 50/1/0/0/0",
               wcnt - w0, ecnt - e0, bcnt - b0, dcnt - d0, busy);
    end
    // Follow-up packet at the upper layer boundary, neuron 1
    w0 = wcnt; d0 = dcnt; e0 = ecnt;
    exp_layer = 33'd3; exp_neuron = 33'd1;
    drive_packet(3, 1, 16'hBEEF, 1'b0);
    tick(3);
    total++;
    if (wcnt - w0 != NW || dcnt - d0 != 1 || ecnt != e0 || bval !== 16'hBEEF || cfgbad != 0) begin
      bad++;
      $display("FAIL after_early: got w=%0d d=%0d err=%0d bias=%h cfgbad=%0d need %0d/1/0/beef/0",
               wcnt - w0, dcnt - d0, ecnt - e0, bval, cfgbad, NW);
    end
  endtask

  task automatic test_bias_no_last();
    int w0, b0, d0, e0;
    w0 = wcnt; b0 = bcnt; d0 = dcnt; e0 = ecnt;
    exp_layer = 33'd1; exp_neuron = 33'd7;
    send_word({16'd1, 16'd7}, 1'b0, 1'b0);
    for (int i = 0; i < NW; i++) send_word(32'(i), 1'b0, 1'b0);
    send_word(32'h1234, 1'b0, 1'b0);
    send_word(32'hAAAA, 1'b0, 1'b0);
    send_word(32'hBBBB, 1'b0, 1'b0);
    send_word(32'hCCCC, 1'b1, 1'b0);
    tick(3);
    total++;
    if (bcnt - b0 != 1 || bval !== 16'h1234) begin
      bad++;
      $display("FAIL bias_nolast_bias: got count=%0d val=%h need 1/1234", bcnt - b0, bval);
    end
    total++;
    if (ecnt - e0 != 1 || dcnt != d0 || wcnt - w0 != NW || busy !== 1'b0) begin
      bad++;
      $display("FAIL bias_nolast_status: got err=%0d d=%0d w=%0d busy=%0b need 1/0/%0d/0",
               ecnt - e0, dcnt - d0, wcnt - w0, busy, NW);
    end
  endtask

  task automatic test_reset_mid();
    int w0, d0, e0;
    w0 = wcnt;
    exp_layer = 33'd2; exp_neuron = 33'd3;
    send_word({16'd2, 16'd3}, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send_word(32'(i + 100), 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (weightValid !== 1'b0 || weightValue !== '0 || busy !== 1'b0 ||
        config_layer_num !== '0 || config_neuron_num !== '0) begin
      bad++;
      $display("FAIL async_reset: got wv=%0b wval=%h busy=%0b cfg=%0d/%0d need 0/0/0/0/0",
               weightValid, weightValue, busy, config_layer_num, config_neuron_num);
    end
    tick(2);
    rst = 1'b0;
    tick(3);
    total++;
    if (wcnt - w0 != 10) begin
      bad++;
      $display("FAIL reset_no_strobes: got %0d weights need 10", wcnt - w0);
    end
    w0 = wcnt; d0 = dcnt; e0 = ecnt;
    exp_layer = 33'd3; exp_neuron = 33'd32;
    drive_packet(3, 32, 16'h0001, 1'b0);
    tick(3);
    total++;
    if (wcnt - w0 != NW || dcnt - d0 != 1 || ecnt != e0) begin
      bad++;
      $display("FAIL after_reset: got w=%0d d=%0d err=%0d need %0d/1/0",
               wcnt - w0, dcnt - d0, ecnt - e0, NW);
    end
  endtask

  initial begin
    test_reset();
    test_legal_packet(1'b0);
    test_bad_header();
    test_early_last();
    test_bias_no_last();
    test_reset_mid();
    test_legal_packet(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
